game_ctrl_multi: RTL and testbench
==================================

# game_ctrl_multi

Parametrised turn-based game controller for N players: sequences initial, waiting, setting, gaming and settlement phases, checks each move against the previous move, enforces a per-turn timeout, keeps per-player scores to a target, and can drive the last player slot from an internal LFSR opponent (PvE). It sits between the button/switch conditioning logic (which delivers one-cycle pulses) and the display/audio blocks, which consume its registered state, turn, timer and score outputs.

## Interface
- NUM_PLAYERS, 2: player count, 2..8; PW = max(1, clog2(NUM_PLAYERS)).
- SYM_W, 2: move symbol width.
- SCORE_W, 4: per-player score width; saturates at all-ones.
- BASE_TICKS, 8: turn timeout in ticks at speed 0; TIMER_W = clog2(BASE_TICKS+1).
- TARGET_DEFAULT, 3: target score after reset.
- CPU_DELAY, 2: ticks the CPU player waits before moving.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- tick  in  1  one-cycle time-base enable.
- start_p  in  1  one-cycle start pulse.
- set_p  in  1  one-cycle set pulse.
- move_valid  in  NUM_PLAYERS  per-player move strobe.
- move  in  NUM_PLAYERS*SYM_W  per-player symbol; player p at [p*SYM_W +: SYM_W].
- cfg_pve  in  1  PvE mode request.
- cfg_speed  in  2  speed request.
- cfg_target  in  SCORE_W  target score request.
- state  out  3  0 INITIAL, 1 WAITING, 2 GAMING, 3 SETTLEMENT, 4 SETTING.
- turn  out  PW  active player.
- last_move  out  SYM_W  last accepted symbol.
- time_left  out  TIMER_W  remaining ticks in current turn.
- round_winner  out  PW  winner of last round.
- winner_valid  out  1  high throughout SETTLEMENT.
- match_over  out  1  some score reached target.
- scores  out  NUM_PLAYERS*SCORE_W  packed scores, player p at [p*SCORE_W +: SCORE_W].
- pve_active  out  1  latched PvE setting.

## Operation
- Reset: state INITIAL; turn, last_move, time_left, round_winner, scores 0; winner_valid, match_over, pve_active 0; speed 0; target TARGET_DEFAULT; LFSR 8'h01.
- INITIAL: next cycle WAITING; clears scores, match_over.
- WAITING: start_p -> GAMING (turn 0, round setup); else set_p -> SETTING; start_p wins if simultaneous.
- SETTING: on set_p latch cfg_pve, cfg_speed, cfg_target (0 treated as 1) -> WAITING; start_p ignored.
- Round setup: has_last=0, time_left = max(1, BASE_TICKS >> speed), winner_valid 0.
- GAMING: only move_valid[turn] accepted; others ignored. Accepted move with has_last=1 and move == last_move -> loss. Otherwise last_move <= move, has_last <= 1, turn <= (turn+1) mod NUM_PLAYERS, time_left reloaded.
- Timeout: tick with time_left==1 and no accepted move -> loss; otherwise tick decrements time_left.
- Loss: round_winner = (turn-1) mod NUM_PLAYERS; score[winner] +1 saturating; match_over set if new score >= target; -> SETTLEMENT; turn holds the loser.
- set_p in GAMING: abort -> WAITING, scores unchanged; overrides move/timeout same cycle.
- Accepted move and timeout tick same cycle: move wins.
- SETTLEMENT: start_p -> if match_over, WAITING with scores and match_over cleared; else GAMING round setup with turn = loser. set_p ignored.
- PvE: player NUM_PLAYERS-1 is CPU; its move_valid ignored. On CPU turn, after CPU_DELAY ticks (counter restarts each turn), CPU move = LFSR[SYM_W-1:0], checked like a human move. If CPU_DELAY >= time_left, timeout applies first.
- LFSR: 8-bit Galois, taps x^8+x^6+x^5+x^4+1, advances every clk in all states.

## Timing
- All outputs registered; changes visible one cycle after causing edge.
- Move sampled at edge with move_valid high; turn/last_move/time_left update same edge; state SETTLEMENT and score update same edge as loss.
- Timeout edge: tick edge with time_left==1; time_left shows 0 in SETTLEMENT.
- Pulses outside their accepting states ignored; no queuing.
- rst asserted mid-round: immediate return to reset values, scores lost.

## Test plan
- NUM_PLAYERS=3, BASE_TICKS=8: start_p; P0 move 1, P1 move 2, P2 move 2 -> SETTLEMENT, round_winner 1, scores[1]=1, turn 2.
- Speed 2 via SETTING, start, 2 ticks no move -> timeout, round_winner 2 (turn 0 loses), time_left 0.
- Target 1 latched: one loss -> match_over 1; start_p -> WAITING, all scores 0.
- Same-cycle P0 move and timeout tick -> move accepted, turn 1, time_left 8; same-cycle set_p + move -> WAITING, scores unchanged.
- PvE, NUM_PLAYERS=2: P1 move_valid pulses ignored; CPU moves exactly CPU_DELAY ticks into its turn with LFSR-derived symbol.
- rst asserted mid-GAMING with scores[0]=2 -> state 0, all outputs reset next edge; score saturates at 15 with target 15 under repeated wins.

Source files
------------

// File: rtl/game_ctrl_multi.sv
// Turn-based game controller for NUM_PLAYERS players: phase sequencing, move
// checking, per-turn timeout, saturating scores and an optional LFSR opponent.
module game_ctrl_multi #(
   parameter  int NUM_PLAYERS    = 2,
   parameter  int SYM_W          = 2,
   parameter  int SCORE_W        = 4,
   parameter  int BASE_TICKS     = 8,
   parameter  int TARGET_DEFAULT = 3,
   parameter  int CPU_DELAY      = 2,
   localparam int PW             = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1,
   localparam int TIMER_W        = $clog2(BASE_TICKS + 1)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           tick,
   input  logic                           start_p,
   input  logic                           set_p,
   input  logic [NUM_PLAYERS-1:0]         move_valid,
   input  logic [NUM_PLAYERS*SYM_W-1:0]   move,
   input  logic                           cfg_pve,
   input  logic [1:0]                     cfg_speed,
   input  logic [SCORE_W-1:0]             cfg_target,
   output logic [2:0]                     state,
   output logic [PW-1:0]                  turn,
   output logic [SYM_W-1:0]               last_move,
   output logic [TIMER_W-1:0]             time_left,
   output logic [PW-1:0]                  round_winner,
   output logic                           winner_valid,
   output logic                           match_over,
   output logic [NUM_PLAYERS*SCORE_W-1:0] scores,
   output logic                           pve_active
);

   typedef enum logic [2:0] {
      ST_INITIAL = 3'd0,
      ST_WAITING = 3'd1,
      ST_GAMING  = 3'd2,
      ST_SETTLE  = 3'd3,
      ST_SETTING = 3'd4
   } state_e;

   localparam int             CD_W    = (CPU_DELAY < 2) ? 1 : $clog2(CPU_DELAY + 1);
   localparam logic [PW-1:0]  LAST_ID = PW'(NUM_PLAYERS - 1);

   state_e               state_q;
   logic [PW-1:0]        turn_q, round_winner_q;
   logic [SYM_W-1:0]     last_move_q;
   logic [TIMER_W-1:0]   time_left_q;
   logic                 winner_valid_q, match_over_q, pve_q, has_last_q;
   logic [1:0]           speed_q;
   logic [SCORE_W-1:0]   target_q;
   logic [7:0]           lfsr_q;
   logic [CD_W-1:0]      cpu_cnt_q;
   logic [SCORE_W-1:0]   score_q [NUM_PLAYERS];

   logic [TIMER_W-1:0]   reload;
   logic [7:0]           lfsr_d;
   logic                 cpu_turn, human_mv, cpu_mv, timeout, mv_en, lose;
   logic [SYM_W-1:0]     mv_sym;
   logic [PW-1:0]        turn_nxt, prev_player;
   logic [SCORE_W-1:0]   win_score;

   // NOTE: every always_comb output is assigned before any conditional use, so no latch is inferred.
   always_comb begin
      reload = TIMER_W'(BASE_TICKS >> speed_q);
      if (reload == '0) reload = TIMER_W'(1);
      lfsr_d      = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? 8'hB8 : 8'h00);
      cpu_turn    = pve_q && (turn_q == LAST_ID);
      human_mv    = move_valid[turn_q] && !cpu_turn;
      cpu_mv      = cpu_turn && ((CPU_DELAY == 0) || (tick && (int'(cpu_cnt_q) == CPU_DELAY - 1)));
      timeout     = tick && (time_left_q == TIMER_W'(1));
      // A human move beats a same-cycle timeout; the CPU's scheduled move does not.
      mv_en       = human_mv || (cpu_mv && !timeout);
      mv_sym      = cpu_turn ? lfsr_q[SYM_W-1:0] : move[int'(turn_q)*SYM_W +: SYM_W];
      lose        = mv_en ? (has_last_q && (mv_sym == last_move_q)) : timeout;
      turn_nxt    = (turn_q == LAST_ID) ? '0 : turn_q + 1'b1;
      prev_player = (turn_q == '0) ? LAST_ID : turn_q - 1'b1;
      win_score   = score_q[prev_player];
      if (win_score != '1) win_score = win_score + 1'b1;
   end

   // NOTE: sequential state uses non-blocking assignments only; the small score file is reset with the rest.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= ST_INITIAL;
         turn_q         <= '0;
         round_winner_q <= '0;
         last_move_q    <= '0;
         time_left_q    <= '0;
         winner_valid_q <= 1'b0;
         match_over_q   <= 1'b0;
         pve_q          <= 1'b0;
         has_last_q     <= 1'b0;
         speed_q        <= 2'd0;
         target_q       <= SCORE_W'(TARGET_DEFAULT);
         lfsr_q         <= 8'h01;
         cpu_cnt_q      <= '0;
         for (int p = 0; p < NUM_PLAYERS; p++) score_q[p] <= '0;
      end else begin
         lfsr_q <= lfsr_d;
         case (state_q)
            ST_INITIAL: begin
               for (int p = 0; p < NUM_PLAYERS; p++) score_q[p] <= '0;
               match_over_q <= 1'b0;
               state_q      <= ST_WAITING;
            end
            ST_WAITING: begin
               if (start_p) begin
                  turn_q         <= '0;
                  has_last_q     <= 1'b0;
                  time_left_q    <= reload;
                  winner_valid_q <= 1'b0;
                  cpu_cnt_q      <= '0;
                  state_q        <= ST_GAMING;
               end else if (set_p) begin
                  state_q <= ST_SETTING;
               end
            end
            ST_SETTING: begin
               if (set_p) begin
                  pve_q    <= cfg_pve;
                  speed_q  <= cfg_speed;
                  target_q <= (cfg_target == '0) ? SCORE_W'(1) : cfg_target;
                  state_q  <= ST_WAITING;
               end
            end
            ST_GAMING: begin
               if (set_p) begin
                  state_q <= ST_WAITING;
               end else if (lose) begin
                  round_winner_q       <= prev_player;
                  score_q[prev_player] <= win_score;
                  match_over_q         <= (win_score >= target_q);
                  winner_valid_q       <= 1'b1;
                  time_left_q          <= '0;
                  state_q              <= ST_SETTLE;
               end else if (mv_en) begin
                  last_move_q <= mv_sym;
                  has_last_q  <= 1'b1;
                  turn_q      <= turn_nxt;
                  time_left_q <= reload;
                  cpu_cnt_q   <= '0;
               end else if (tick) begin
                  time_left_q <= time_left_q - 1'b1;
                  if (cpu_turn) cpu_cnt_q <= cpu_cnt_q + 1'b1;
               end
            end
            ST_SETTLE: begin
               if (start_p) begin
                  winner_valid_q <= 1'b0;
                  if (match_over_q) begin
                     for (int p = 0; p < NUM_PLAYERS; p++) score_q[p] <= '0;
                     match_over_q <= 1'b0;
                     state_q      <= ST_WAITING;
                  end else begin
                     // The loser of the previous round opens the next one.
                     has_last_q  <= 1'b0;
                     time_left_q <= reload;
                     cpu_cnt_q   <= '0;
                     state_q     <= ST_GAMING;
                  end
               end
            end
            default: state_q <= ST_INITIAL;
         endcase
      end
   end

   assign state        = state_q;
   assign turn         = turn_q;
   assign last_move    = last_move_q;
   assign time_left    = time_left_q;
   assign round_winner = round_winner_q;
   assign winner_valid = winner_valid_q;
   assign match_over   = match_over_q;
   assign pve_active   = pve_q;

   for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_scores
      assign scores[g*SCORE_W +: SCORE_W] = score_q[g];
   end

endmodule

// File: tb/tb_game_ctrl_multi.sv
// Directed bench for game_ctrl_multi: a 3-player instance for the human game
// flow and a 2-player instance for the LFSR opponent.
module tb_game_ctrl_multi;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // 3-player instance
   logic        rst, tick, start_p, set_p, cfg_pve;
   logic [2:0]  move_valid;
   logic [5:0]  move;
   logic [1:0]  cfg_speed;
   logic [3:0]  cfg_target;
   logic [2:0]  state;
   logic [1:0]  turn, last_move, round_winner;
   logic [3:0]  time_left;
   logic        winner_valid, match_over, pve_active;
   logic [11:0] scores;

   // 2-player PvE instance
   logic        b_rst, b_tick, b_start, b_set, b_cfg_pve;
   logic [1:0]  b_move_valid;
   logic [3:0]  b_move;
   logic [1:0]  b_cfg_speed;
   logic [3:0]  b_cfg_target;
   logic [2:0]  b_state;
   logic [0:0]  b_turn, b_round_winner;
   logic [1:0]  b_last_move;
   logic [3:0]  b_time_left;
   logic        b_winner_valid, b_match_over, b_pve_active;
   logic [7:0]  b_scores;

   game_ctrl_multi #(.NUM_PLAYERS(3), .BASE_TICKS(8)) dut3 (
      .clk(clk), .rst(rst), .tick(tick), .start_p(start_p), .set_p(set_p),
      .move_valid(move_valid), .move(move), .cfg_pve(cfg_pve), .cfg_speed(cfg_speed),
      .cfg_target(cfg_target), .state(state), .turn(turn), .last_move(last_move),
      .time_left(time_left), .round_winner(round_winner), .winner_valid(winner_valid),
      .match_over(match_over), .scores(scores), .pve_active(pve_active)
   );

   game_ctrl_multi #(.NUM_PLAYERS(2), .BASE_TICKS(8)) dut2 (
      .clk(clk), .rst(b_rst), .tick(b_tick), .start_p(b_start), .set_p(b_set),
      .move_valid(b_move_valid), .move(b_move), .cfg_pve(b_cfg_pve), .cfg_speed(b_cfg_speed),
      .cfg_target(b_cfg_target), .state(b_state), .turn(b_turn), .last_move(b_last_move),
      .time_left(b_time_left), .round_winner(b_round_winner), .winner_valid(b_winner_valid),
      .match_over(b_match_over), .scores(b_scores), .pve_active(b_pve_active)
   );

   // Reference LFSR: x^8+x^6+x^5+x^4+1 Galois form, seeded with 8'h01.
   logic [7:0] lfsr_ref;
   always @(posedge clk or posedge b_rst) begin
      if (b_rst) lfsr_ref <= 8'h01;
      else       lfsr_ref <= lfsr_ref[0] ? ((lfsr_ref >> 1) ^ 8'hB8) : (lfsr_ref >> 1);
   end

   int n_assert = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_assert++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      start_p = 1'b1; cyc(); start_p = 1'b0;
   endtask

   task automatic do_set();
      set_p = 1'b1; cyc(); set_p = 1'b0;
   endtask

   task automatic do_tick();
      tick = 1'b1; cyc(); tick = 1'b0;
   endtask

   task automatic do_move(input int p, input logic [1:0] s);
      move_valid = 3'b000;
      move_valid[p] = 1'b1;
      move[p*2 +: 2] = s;
      cyc();
      move_valid = 3'b000;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [1:0] cpu_sym;
      rst = 1'b1; tick = 0; start_p = 0; set_p = 0; cfg_pve = 0;
      move_valid = '0; move = '0; cfg_speed = '0; cfg_target = 4'd3;
      b_rst = 1'b1; b_tick = 0; b_start = 0; b_set = 0; b_cfg_pve = 0;
      b_move_valid = '0; b_move = '0; b_cfg_speed = '0; b_cfg_target = 4'd3;
      cyc(); cyc();

      check("reset_state", state, 0);
      check("reset_turn", turn, 0);
      check("reset_time", time_left, 0);
      check("reset_scores", scores, 0);
      check("reset_flags", {winner_valid, match_over, pve_active}, 0);

      rst = 1'b0; b_rst = 1'b0;
      cyc();
      check("init_to_wait", state, 1);

      // Round with a repeated symbol: P2 repeats P1, so P1 wins.
      do_start();
      check("start_state", state, 2);
      check("start_time", time_left, 8);
      do_move(0, 2'd1);
      check("p0_turn", turn, 1);
      check("p0_last", last_move, 1);
      do_move(2, 2'd3);
      check("offturn_ignored", {turn, last_move}, {2'd1, 2'd1});
      do_move(1, 2'd2);
      check("p1_turn", turn, 2);
      do_move(2, 2'd2);
      check("loss_state", state, 3);
      check("loss_winner", round_winner, 1);
      check("loss_scores", scores, 12'h010);
      check("loss_turn", turn, 2);
      check("loss_flags", {winner_valid, match_over}, 2'b10);
      do_set();
      check("settle_set_ignored", state, 3);
      do_start();
      check("settle_restart", {state, turn, time_left}, {3'd2, 2'd2, 4'd8});
      check("restart_wv_low", winner_valid, 0);

      // Abort overrides a same-cycle move.
      set_p = 1'b1; move_valid = 3'b100; move = 6'b00_00_00;
      cyc();
      set_p = 1'b0; move_valid = '0;
      check("abort_state", state, 1);
      check("abort_scores", scores, 12'h010);
      check("abort_turn", turn, 2);

      // Two wins for P0, then reset mid-round.
      do_start();
      do_move(0, 2'd1);
      do_move(1, 2'd1);
      check("p0_win1", {round_winner, scores}, {2'd0, 12'h011});
      do_start();
      check("restart_loser_turn", turn, 1);
      do_move(1, 2'd1);
      do_move(2, 2'd2);
      do_move(0, 2'd3);
      do_move(1, 2'd3);
      check("p0_win2", scores, 12'h012);
      do_start();
      check("gaming_before_rst", state, 2);
      rst = 1'b1;
      #1;
      check("async_rst_state", state, 0);
      check("async_rst_scores", scores, 0);
      cyc();
      check("rst_outputs", {turn, last_move, time_left, round_winner, winner_valid, match_over, pve_active}, 0);
      rst = 1'b0;
      cyc();
      check("rst_to_wait", state, 1);

      // Move and timeout tick on the same edge: the move wins.
      do_start();
      for (int i = 0; i < 7; i++) do_tick();
      check("time_at_one", time_left, 1);
      tick = 1'b1; move_valid = 3'b001; move = 6'b00_00_01;
      cyc();
      tick = 1'b0; move_valid = '0;
      check("move_beats_timeout", {state, turn, time_left}, {3'd2, 2'd1, 4'd8});
      do_set();
      check("abort2_state", state, 1);

      // Configuration: speed 2, target 0 (treated as 1).
      do_set();
      check("setting_state", state, 4);
      do_start();
      check("setting_start_ignored", state, 4);
      cfg_speed = 2'd2; cfg_target = 4'd0;
      do_set();
      check("setting_done", state, 1);
      start_p = 1'b1; set_p = 1'b1;
      cyc();
      start_p = 1'b0; set_p = 1'b0;
      check("start_beats_set", state, 2);
      check("speed2_time", time_left, 2);
      do_tick();
      check("speed2_dec", time_left, 1);
      do_tick();
      check("timeout_state", state, 3);
      check("timeout_winner", round_winner, 2);
      check("timeout_time", time_left, 0);
      check("timeout_turn", turn, 0);
      check("timeout_scores", scores, 12'h100);
      check("target1_match_over", match_over, 1);
      do_start();
      check("match_end_state", state, 1);
      check("match_end_clear", {scores, match_over, winner_valid}, 0);

      // Target 15, speed 3: P2 wins every round by timeout of P0.
      do_set();
      cfg_speed = 2'd3; cfg_target = 4'd15;
      do_set();
      for (int k = 1; k <= 15; k++) begin
         do_start();
         do_tick();
         check($sformatf("rep_score_%0d", k), scores, {4'(k), 8'h00});
         if (k == 14) check("rep_mo_14", match_over, 0);
      end
      check("rep_mo_15", match_over, 1);
      do_start();
      check("rep_clear", {state, scores}, {3'd1, 12'h000});

      // PvE on the 2-player instance.
      b_set = 1'b1; cyc(); b_set = 1'b0;
      b_cfg_pve = 1'b1;
      b_set = 1'b1; cyc(); b_set = 1'b0;
      check("pve_latched", {b_state, b_pve_active}, {3'd1, 1'b1});
      b_start = 1'b1; cyc(); b_start = 1'b0;
      b_move_valid = 2'b01; b_move = 4'b00_01;
      cyc();
      b_move_valid = '0;
      check("pve_p0_move", {b_turn, b_last_move, b_time_left}, {1'b1, 2'd1, 4'd8});
      b_move_valid = 2'b10; b_move = 4'b01_00;
      cyc();
      b_move_valid = '0;
      check("pve_cpu_strobe_ignored", {b_state, b_turn, b_last_move}, {3'd2, 1'b1, 2'd1});
      b_tick = 1'b1; cyc(); b_tick = 1'b0;
      check("pve_cpu_waits", {b_turn, b_time_left}, {1'b1, 4'd7});
      cpu_sym = lfsr_ref[1:0];
      b_tick = 1'b1; cyc(); b_tick = 1'b0;
      if (cpu_sym == 2'd1) begin
         check("pve_cpu_repeat", {b_state, b_round_winner, b_turn}, {3'd3, 1'b0, 1'b1});
      end else begin
         check("pve_cpu_move", {b_state, b_turn, b_last_move, b_time_left},
               {3'd2, 1'b0, cpu_sym, 4'd8});
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
